// File: rtl/mem_x_streamer.sv
// -----------------------------------------------------------------------------
// mem_x_streamer
//   Read-side master for a single-port sample memory (x1/x2/weights). A start
//   pulse streams `count` words beginning at `base` (wrapping DEPTH-1 -> 0) out
//   of the memory's 1-cycle registered read port and presents them as a
//   valid/ready stream of Q6.9 samples. Sample data passes through unmodified.
//
//   A 2-entry FIFO absorbs the read latency. A read is issued only when the
//   words already buffered plus the word on data_out still leave a free slot,
//   so backpressure can never overflow the buffer or drop/repeat a sample.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start, base, count run request; sampled only while idle
//   mem_ena, wr_rd,    memory control (wr_rd tied low, read only)
//   addr, data_out     read address / read data (valid 1 cycle after mem_ena)
//   x_data, x_valid,   output stream; x_last marks word number `count`
//   x_ready, x_last
//   busy, done         busy from the cycle after start until done; done pulses
//                      once after the final word transfers
// -----------------------------------------------------------------------------
module mem_x_streamer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  output logic              mem_ena,
  output logic              wr_rd,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] x_data,
  output logic              x_valid,
  input  logic              x_ready,
  output logic              x_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                       state_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [ADDR_W-1:0]            remain_q;   // reads still to issue
  logic [ADDR_W-1:0]            total_q;    // words in this run
  logic [ADDR_W-1:0]            sent_q;     // words already transferred
  logic                         in_flight_q;
  logic [1:0][DATA_W-1:0]       buf_q;
  logic                         rd_ptr_q;
  logic                         wr_ptr_q;
  logic [1:0]                   occ_q;

  logic                         pop;
  logic                         push;
  logic [1:0]                   occ_after_pop;
  logic [2:0]                   pending;
  logic [ADDR_W-1:0]            addr_d;
  logic [ADDR_W-1:0]            last_idx;

  assign x_valid       = (occ_q != 2'd0);
  assign pop           = x_valid & x_ready;
  // The word read last cycle is on data_out now and lands in the buffer at
  // this edge.
  assign push          = in_flight_q;
  assign occ_after_pop = occ_q - {1'b0, pop};
  assign pending       = {1'b0, occ_after_pop} + {2'b00, in_flight_q};

  // Issue only if the buffer can still hold this word when it returns.
  // Using the post-pop occupancy keeps 1 word/clk under continuous ready.
  assign mem_ena  = (state_q == S_RUN) && (remain_q != '0) && (pending < 3'd2);

  assign addr_d   = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
  assign last_idx = total_q - ADDR_W'(1);

  assign wr_rd    = 1'b0;
  assign addr     = addr_q;
  assign x_data   = buf_q[rd_ptr_q];
  assign x_last   = x_valid && (sent_q == last_idx);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      total_q     <= '0;
      sent_q      <= '0;
      in_flight_q <= 1'b0;   // any read in flight is simply forgotten
      buf_q       <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      in_flight_q <= mem_ena;

      if (push) begin
        buf_q[wr_ptr_q] <= data_out;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        sent_q   <= sent_q + ADDR_W'(1);
      end
      occ_q <= occ_after_pop + {1'b0, push};

      if (mem_ena) begin
        addr_q   <= addr_d;
        remain_q <= remain_q - ADDR_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          // Buffer is empty and no read is pending here, so these loads never
          // collide with the datapath updates above.
          if (start) begin
            addr_q   <= base;
            remain_q <= count;
            total_q  <= count;
            sent_q   <= '0;
            state_q  <= (count == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (mem_ena && (remain_q == ADDR_W'(1))) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // No reads remain, so the last word leaving means the buffer is empty.
          if (pop && x_last) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_x_streamer.sv
module tb_mem_x_streamer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1024;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] count;
  logic              mem_ena;
  logic              wr_rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] x_data;
  logic              x_valid;
  logic              x_ready;
  logic              x_last;
  logic              busy;
  logic              done;

  int n_chk;
  int n_err;

  logic [DATA_W-1:0] mem [0:2047];

  mem_x_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .mem_ena(mem_ena), .wr_rd(wr_rd), .addr(addr), .data_out(data_out),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready), .x_last(x_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with a 1-cycle registered read; data_out is never reset.
  initial data_out = 16'hDEAD;
  always @(posedge clk)
    if (mem_ena && !wr_rd) data_out <= mem[addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ena"},  mem_ena, 0);
    chk({tag, "_vld"},  x_valid, 0);
    chk({tag, "_last"}, x_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_data"}, x_data, 0);
  endtask

  // One run against the reference: expected stream is mem[(b+i) % DEPTH] for
  // i = 0..c-1, last on i == c-1, first valid two clocks after the accepting
  // edge, done exactly one clock after the final transfer.
  // mode: 0 ready held high, 1 ready pattern 1,0,0, 2 random ready.
  // abort_n > 0: return as soon as that many words have transferred.
  // poke: re-pulse start with other arguments mid-run (must be ignored).
  task automatic run(input int b, input int c, input int mode, input int abort_n, input bit poke);
    int issued, xfer, first_v, done_cyc, done_n, last_cyc, budget;
    bit fin, stall;
    logic [DATA_W-1:0] stall_d;
    issued = 0; xfer = 0; first_v = -1; done_cyc = -1; done_n = 0; last_cyc = -1;
    fin = 0; stall = 0; stall_d = '0;
    budget = c * 8 + 40;
    base = ADDR_W'(b); count = ADDR_W'(c); start = 1'b1; x_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    base  = ADDR_W'($urandom_range(0, DEPTH - 1));
    count = ADDR_W'($urandom_range(1, 50));
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (abort_n > 0 && xfer == abort_n) return;
      case (mode)
        0:       x_ready = 1'b1;
        1:       x_ready = (cyc % 3 == 0);
        default: x_ready = ($urandom_range(0, 99) < 55);
      endcase
      if (poke && cyc == 3) begin
        start = 1'b1; base = 11'd5; count = 11'd7;
      end else begin
        start = 1'b0;
      end
      #1;
      chk("outstanding", (issued - xfer) <= 2, 1);
      if (cyc == 0) chk("busy_first", busy, 1);
      chk("wr_rd", wr_rd, 0);
      if (stall) begin
        chk("stall_valid", x_valid, 1);
        chk("stall_data", x_data, stall_d);
      end
      if (mem_ena) begin
        chk("addr", addr, (b + issued) % DEPTH);
        issued++;
      end
      if (x_valid && first_v < 0) first_v = cyc;
      if (x_valid && x_ready) begin
        chk("data", x_data, mem[(b + xfer) % DEPTH]);
        chk("last", x_last, (xfer == c - 1));
        xfer++;
        if (xfer == c) last_cyc = cyc;
      end
      stall   = x_valid && !x_ready;
      stall_d = x_data;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("idle_after", {busy, done, x_valid, mem_ena}, 0);
        fin = 1;
        break;
      end
      @(posedge clk); @(negedge clk);
    end
    start = 1'b0;
    chk("timeout", fin, 1);
    chk("n_issue", issued, c);
    chk("n_xfer", xfer, c);
    chk("done_n", done_n, 1);
    chk("done_cyc", done_cyc, last_cyc + 1);
    if (c > 0) chk("latency", first_v, 2);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    for (int i = 0; i < 2048; i++) mem[i] = DATA_W'($urandom);
    mem[0] = 16'h0200; mem[1] = 16'hFE00; mem[2] = 16'h0080; mem[3] = 16'h7FFF;

    rst = 1'b1; start = 1'b0; base = '0; count = '0; x_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run(0, 4, 0, 0, 0);        // basic stream, ready held high
    run(0, 4, 1, 0, 0);        // same words under backpressure
    run(1022, 4, 0, 0, 0);     // address wrap 1022,1023,0,1
    run(0, 0, 0, 0, 0);        // empty run: done only

    // Reset in the middle of a run after two words.
    run(0, 4, 0, 2, 0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk_all_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    run(0, 2, 0, 0, 0);

    run(0, 4, 0, 0, 1);        // start while busy is ignored
    run(10, 6, 1, 0, 1);

    for (int r = 0; r < 8; r++)
      run($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 2, 0, r[0]);
    run(1000, 40, 2, 0, 0);

    // Reset takes priority over a simultaneous start.
    rst = 1'b1; start = 1'b1; base = 11'd3; count = 11'd3;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; start = 1'b0; #1;
    chk("rst_start_busy", busy, 0);
    @(posedge clk); @(negedge clk); #1;
    chk("rst_start_ena", {busy, mem_ena, x_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
